stream_mux_rr: RTL and testbench
================================

Name: stream_mux_rr

Overview:
- Parametrised successor to the combinational 4-way mux: an N-channel, W-bit stream multiplexer with valid/ready handshakes and a registered output stage.
- Two selection modes:
  - round-robin arbitration, with a packet lock held until the last beat;
  - externally fixed select, as in the old mux but registered and flow-controlled.
- Sits between CPU-side producers (fetch, load/store, debug) and a shared bus or memory port.

Parameters:
- WIDTH, 4, data width per channel in bits.
- CHANNELS, 4, number of input channels (2..16).
- SEL_BITS, 2, width of select/index signals; must satisfy 2**SEL_BITS >= CHANNELS.

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_data  input  CHANNELS*WIDTH  flattened channel data; channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  input  CHANNELS  per-channel valid.
- in_last  input  CHANNELS  per-channel end-of-packet marker.
- in_ready  output  CHANNELS  per-channel ready.
- mode  input  1  0 = round-robin, 1 = fixed select.
- fixed_sel  input  SEL_BITS  channel index used when mode = 1.
- out_data  output  WIDTH  registered data.
- out_sel  output  SEL_BITS  source channel of the current out_data.
- out_last  output  1  registered last marker.
- out_valid  output  1  output holds a beat.
- out_ready  input  1  downstream accepts.

Behaviour:
- Reset (asynchronous, active-high):
  - Registers: out_valid=0, out_data=0, out_sel=0, out_last=0.
  - Internal: rr_ptr=0, state=IDLE, lock_ch=0.
  - Outputs: in_ready=0 while reset is asserted.
- Reset mid-packet: the partial packet is abandoned, the output beat is dropped, and no beat is emitted after deassertion until new requests arrive.
- Output stage is a single register. load_en = !out_valid | out_ready.
- Combinational grant vector g, at most one bit set:
  - IDLE, mode=0: first valid channel scanning rr_ptr, rr_ptr+1, ... modulo CHANNELS.
  - IDLE, mode=1: g[fixed_sel] = in_valid[fixed_sel]. No grant if fixed_sel >= CHANNELS.
  - LOCKED: g[lock_ch] = in_valid[lock_ch]. Other channels stall regardless of mode.
- in_ready[i] = g[i] & load_en & !reset. A transfer on channel i occurs when in_valid[i] & in_ready[i].
- On a transfer from channel c, at the next edge:
  - out_data  = in_data[c]
  - out_sel   = c
  - out_last  = in_last[c]
  - out_valid = 1
- If out_valid & out_ready with no transfer, out_valid goes to 0 at the next edge.
- Throughput: simultaneous output accept and input load gives one beat per cycle sustained.
- Latency: one cycle from input transfer to out_valid.
- State machine:
  - IDLE -> LOCKED: on a transfer with in_last=0. lock_ch = c.
  - LOCKED -> IDLE: on a transfer with in_last=1.
  - A transfer with in_last=1 in IDLE stays in IDLE (single-beat packet).
- rr_ptr update:
  - On any transfer with in_last=1: rr_ptr = (c+1) mod CHANNELS, wrapping at CHANNELS-1 to 0.
  - rr_ptr is unchanged in mode=1, so the fairness position is retained across mode switches.
- mode and fixed_sel are sampled only in IDLE. Changes during LOCKED take effect after the packet ends.
- Output stability: while out_valid=1 and out_ready=0, out_data, out_sel and out_last hold stable.
- in_ready never depends combinationally on in_valid of other channels in LOCKED state.
- No request: g=0, no state change.

Decomposition:
- Shared package/header (cpu_defs):
  - mode encodings MODE_RR=1'b0, MODE_FIXED=1'b1;
  - state encodings ST_IDLE, ST_LOCKED.
- One natural sub-module: rr_arbiter (CHANNELS, SEL_BITS).
  - Inputs: request vector, rr_ptr, enable.
  - Outputs: one-hot grant plus encoded index.
  - Purely combinational; reused later by the bus interconnect.
- Data mux, output register and FSM stay in stream_mux_rr.

Test Plan:
1. Fixed mode, WIDTH=4, CHANNELS=4, inputs 0x0/0x1/0x5/0xF all valid with last=1, out_ready=1, fixed_sel stepping 0..3 every cycle -> out_data 0x0,0x1,0x5,0xF one cycle later each, out_sel 0..3; in_ready only on the selected channel.
2. Round-robin, all four valid with last=1 continuously, out_ready=1 -> grant order 0,1,2,3,0,... and out_sel sequence 0,1,2,3,0 with one beat per cycle.
3. Packet lock: channel 1 sends 3 beats (last on beat 3) while channels 0 and 2 are valid -> out_sel=1 for three consecutive beats, then channel 2 next (rr_ptr=2), then 0.
4. Backpressure: out_ready=0 for 5 cycles with a beat held (out_data=0xA) -> out_valid stays 1, data stable, all in_ready=0; on out_ready=1 the next beat loads in the same cycle.
5. Reset mid-packet: assert reset asynchronously (not edge-aligned) during beat 2 of a channel-3 packet -> outputs zero immediately; after release, state IDLE, rr_ptr=0, so channel 0 wins when channels 0 and 3 are both valid.
6. Edge cases, CHANNELS=3, SEL_BITS=2, fixed_sel=3 -> no grant and out_valid stays 0; mode switched mid-packet -> lock held until last, new mode applies afterwards.

Source files
------------

// File: rtl/stream_mux_rr_pkg.sv
// Shared definitions for the stream multiplexer: mode and FSM state encodings.
package stream_mux_rr_pkg;

  localparam logic MODE_RR    = 1'b0;
  localparam logic MODE_FIXED = 1'b1;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester at or after ptr,
// wrapping modulo CHANNELS. Returns both a one-hot grant and its encoded index.
module rr_arbiter #(
  parameter int CHANNELS = 4,
  parameter int SEL_BITS = 2
) (
  input  logic [CHANNELS-1:0] req,
  input  logic [SEL_BITS-1:0] ptr,
  input  logic                enable,
  output logic [CHANNELS-1:0] grant,
  output logic [SEL_BITS-1:0] grant_idx
);

  // Rotating priority scan starting at ptr; first hit wins.
  always_comb begin
    int                  pos;
    logic [SEL_BITS-1:0] pos_idx;
    logic                found;
    logic                hit;
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    pos       = 0;
    pos_idx   = '0;
    hit       = 1'b0;
    for (int k = 0; k < CHANNELS; k++) begin
      pos            = ((int'(ptr) + k) >= CHANNELS) ? (int'(ptr) + k - CHANNELS) : (int'(ptr) + k);
      pos_idx        = SEL_BITS'(pos);
      hit            = enable & ~found & req[pos_idx];
      grant[pos_idx] = grant[pos_idx] | hit;
      grant_idx      = hit ? pos_idx : grant_idx;
      found          = found | hit;
    end
  end

endmodule

// File: rtl/stream_mux_rr.sv
// N-channel valid/ready stream multiplexer with a registered output stage.
// Round-robin arbitration with packet lock, or an externally fixed select.
module stream_mux_rr
  import stream_mux_rr_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int CHANNELS = 4,
  parameter int SEL_BITS = 2
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  input  logic [CHANNELS-1:0]       in_last,
  output logic [CHANNELS-1:0]       in_ready,
  input  logic                      mode,
  input  logic [SEL_BITS-1:0]       fixed_sel,
  output logic [WIDTH-1:0]          out_data,
  output logic [SEL_BITS-1:0]       out_sel,
  output logic                      out_last,
  output logic                      out_valid,
  input  logic                      out_ready
);

  localparam logic [SEL_BITS:0]   NUM_CH  = (SEL_BITS + 1)'(CHANNELS);
  localparam logic [SEL_BITS-1:0] LAST_CH = SEL_BITS'(CHANNELS - 1);

  state_e              state_q, state_d;
  logic [SEL_BITS-1:0] lock_ch_q, lock_ch_d;
  logic [SEL_BITS-1:0] rr_ptr_q, rr_ptr_d;
  logic                pkt_mode_q, pkt_mode_d;
  logic                out_valid_q, out_valid_d;
  logic [WIDTH-1:0]    out_data_q, out_data_d;
  logic [SEL_BITS-1:0] out_sel_q, out_sel_d;
  logic                out_last_q, out_last_d;

  logic                load_en;
  logic                eff_mode;
  logic                arb_en;
  logic [CHANNELS-1:0] arb_grant;
  logic [SEL_BITS-1:0] arb_idx;
  logic [CHANNELS-1:0] grant;
  logic [SEL_BITS-1:0] sel_idx;
  logic [WIDTH-1:0]    xfer_data;
  logic                xfer_last;
  logic                xfer;

  assign load_en  = ~out_valid_q | out_ready;
  // A locked packet keeps the mode it started with; live mode only matters in IDLE.
  assign eff_mode = (state_q == ST_LOCKED) ? pkt_mode_q : mode;
  assign arb_en   = (state_q == ST_IDLE) && (mode == MODE_RR);

  rr_arbiter #(
    .CHANNELS (CHANNELS),
    .SEL_BITS (SEL_BITS)
  ) u_arb (
    .req       (in_valid),
    .ptr       (rr_ptr_q),
    .enable    (arb_en),
    .grant     (arb_grant),
    .grant_idx (arb_idx)
  );

  // Grant selection: arbiter, fixed select, or the locked channel.
  always_comb begin
    grant   = '0;
    sel_idx = '0;
    case (state_q)
      ST_IDLE: begin
        if (mode == MODE_RR) begin
          grant   = arb_grant;
          sel_idx = arb_idx;
        end else if ({1'b0, fixed_sel} < NUM_CH) begin
          grant[fixed_sel] = in_valid[fixed_sel];
          sel_idx          = fixed_sel;
        end else begin
          grant   = '0;
          sel_idx = fixed_sel;
        end
      end
      ST_LOCKED: begin
        grant[lock_ch_q] = in_valid[lock_ch_q];
        sel_idx          = lock_ch_q;
      end
      default: begin
        grant   = '0;
        sel_idx = '0;
      end
    endcase
  end

  assign in_ready  = grant & {CHANNELS{load_en & ~reset}};
  assign xfer      = |(in_valid & in_ready);
  assign xfer_last = |(grant & in_last);

  // One-hot data mux driven by the grant vector.
  always_comb begin
    xfer_data = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      xfer_data = xfer_data | ({WIDTH{grant[i]}} & in_data[i*WIDTH +: WIDTH]);
    end
  end

  // Next-state for the FSM, round-robin pointer and output register.
  always_comb begin
    state_d     = state_q;
    lock_ch_d   = lock_ch_q;
    pkt_mode_d  = pkt_mode_q;
    rr_ptr_d    = rr_ptr_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    out_last_d  = out_last_q;
    if (xfer) begin
      out_valid_d = 1'b1;
      out_data_d  = xfer_data;
      out_sel_d   = sel_idx;
      out_last_d  = xfer_last;
      if (xfer_last) begin
        state_d = ST_IDLE;
        if (eff_mode == MODE_RR) begin
          rr_ptr_d = (sel_idx == LAST_CH) ? '0 : (sel_idx + SEL_BITS'(1));
        end else begin
          rr_ptr_d = rr_ptr_q;
        end
      end else begin
        state_d    = ST_LOCKED;
        lock_ch_d  = sel_idx;
        pkt_mode_d = eff_mode;
      end
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      lock_ch_q   <= '0;
      pkt_mode_q  <= MODE_RR;
      rr_ptr_q    <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      lock_ch_q   <= lock_ch_d;
      pkt_mode_q  <= pkt_mode_d;
      rr_ptr_q    <= rr_ptr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
      out_last_q  <= out_last_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;
  assign out_last  = out_last_q;

endmodule

// File: tb/tb_stream_mux_rr.sv
// Directed bench for stream_mux_rr: a vector table for fixed/round-robin/lock
// behaviour plus hand sequences for backpressure, reset and a 3-channel instance.
module tb_stream_mux_rr;

  logic        clock;
  logic        reset;
  logic [15:0] in_data;
  logic [3:0]  in_valid, in_last, in_ready;
  logic        mode;
  logic [1:0]  fixed_sel;
  logic [3:0]  out_data;
  logic [1:0]  out_sel;
  logic        out_last, out_valid, out_ready;

  logic [11:0] c3_in_data;
  logic [2:0]  c3_in_valid, c3_in_last, c3_in_ready;
  logic        c3_mode;
  logic [1:0]  c3_fixed_sel;
  logic [3:0]  c3_out_data;
  logic [1:0]  c3_out_sel;
  logic        c3_out_last, c3_out_valid, c3_out_ready;

  int checks;
  int failures;

  stream_mux_rr #(.WIDTH(4), .CHANNELS(4), .SEL_BITS(2)) dut (
    .clock(clock), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_last(in_last), .in_ready(in_ready), .mode(mode), .fixed_sel(fixed_sel),
    .out_data(out_data), .out_sel(out_sel), .out_last(out_last),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  stream_mux_rr #(.WIDTH(4), .CHANNELS(3), .SEL_BITS(2)) dut3 (
    .clock(clock), .reset(reset), .in_data(c3_in_data), .in_valid(c3_in_valid),
    .in_last(c3_in_last), .in_ready(c3_in_ready), .mode(c3_mode), .fixed_sel(c3_fixed_sel),
    .out_data(c3_out_data), .out_sel(c3_out_sel), .out_last(c3_out_last),
    .out_valid(c3_out_valid), .out_ready(c3_out_ready)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic       mode;
    logic [1:0] fsel;
    logic [3:0] valid;
    logic [3:0] last;
    logic       ordy;
    logic [3:0] exp_rdy;
    logic       exp_ov;
    logic [3:0] exp_data;
    logic [1:0] exp_sel;
    logic       exp_last;
  } vec_t;

  vec_t vecs [15];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic m, input logic [1:0] fs, input logic [3:0] v,
                       input logic [3:0] l, input logic r);
    mode      = m;
    fixed_sel = fs;
    in_valid  = v;
    in_last   = l;
    out_ready = r;
  endtask

  task automatic drive3(input logic m, input logic [1:0] fs, input logic [2:0] v,
                        input logic [2:0] l);
    c3_mode      = m;
    c3_fixed_sel = fs;
    c3_in_valid  = v;
    c3_in_last   = l;
    c3_out_ready = 1'b1;
  endtask

  task automatic chk_out(input string nm, input logic ov, input logic [3:0] d,
                         input logic [1:0] s, input logic l);
    chk({nm, "_valid"}, 32'(out_valid), 32'(ov));
    if (ov) begin
      chk({nm, "_data"}, 32'(out_data), 32'(d));
      chk({nm, "_sel"},  32'(out_sel),  32'(s));
      chk({nm, "_last"}, 32'(out_last), 32'(l));
    end
  endtask

  task automatic chk3(input string nm, input logic ov, input logic [3:0] d,
                      input logic [1:0] s, input logic l);
    chk({nm, "_valid"}, 32'(c3_out_valid), 32'(ov));
    if (ov) begin
      chk({nm, "_data"}, 32'(c3_out_data), 32'(d));
      chk({nm, "_sel"},  32'(c3_out_sel),  32'(s));
      chk({nm, "_last"}, 32'(c3_out_last), 32'(l));
    end
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    clock      = 1'b0;
    reset      = 1'b1;
    in_data    = {4'hF, 4'h5, 4'h1, 4'h0};
    c3_in_data = {4'h9, 4'h6, 4'h3};
    drive(1'b1, 2'd0, 4'hF, 4'hF, 1'b1);
    drive3(1'b0, 2'd0, 3'b000, 3'b000);

    // mode, fsel, valid, last, ordy | in_ready, out_valid, data, sel, last
    vecs[0]  = '{1'b1, 2'd0, 4'b1111, 4'b1111, 1'b1, 4'b0001, 1'b1, 4'h0, 2'd0, 1'b1};
    vecs[1]  = '{1'b1, 2'd1, 4'b1111, 4'b1111, 1'b1, 4'b0010, 1'b1, 4'h1, 2'd1, 1'b1};
    vecs[2]  = '{1'b1, 2'd2, 4'b1111, 4'b1111, 1'b1, 4'b0100, 1'b1, 4'h5, 2'd2, 1'b1};
    vecs[3]  = '{1'b1, 2'd3, 4'b1111, 4'b1111, 1'b1, 4'b1000, 1'b1, 4'hF, 2'd3, 1'b1};
    vecs[4]  = '{1'b0, 2'd0, 4'b1111, 4'b1111, 1'b1, 4'b0001, 1'b1, 4'h0, 2'd0, 1'b1};
    vecs[5]  = '{1'b0, 2'd0, 4'b1111, 4'b1111, 1'b1, 4'b0010, 1'b1, 4'h1, 2'd1, 1'b1};
    vecs[6]  = '{1'b0, 2'd0, 4'b1111, 4'b1111, 1'b1, 4'b0100, 1'b1, 4'h5, 2'd2, 1'b1};
    vecs[7]  = '{1'b0, 2'd0, 4'b1111, 4'b1111, 1'b1, 4'b1000, 1'b1, 4'hF, 2'd3, 1'b1};
    vecs[8]  = '{1'b0, 2'd0, 4'b1111, 4'b1111, 1'b1, 4'b0001, 1'b1, 4'h0, 2'd0, 1'b1};
    vecs[9]  = '{1'b0, 2'd0, 4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 4'h0, 2'd0, 1'b0};
    vecs[10] = '{1'b0, 2'd0, 4'b0111, 4'b0101, 1'b1, 4'b0010, 1'b1, 4'h1, 2'd1, 1'b0};
    vecs[11] = '{1'b0, 2'd0, 4'b0111, 4'b0101, 1'b1, 4'b0010, 1'b1, 4'h1, 2'd1, 1'b0};
    vecs[12] = '{1'b0, 2'd0, 4'b0111, 4'b0111, 1'b1, 4'b0010, 1'b1, 4'h1, 2'd1, 1'b1};
    vecs[13] = '{1'b0, 2'd0, 4'b0101, 4'b0101, 1'b1, 4'b0100, 1'b1, 4'h5, 2'd2, 1'b1};
    vecs[14] = '{1'b0, 2'd0, 4'b0101, 4'b0101, 1'b1, 4'b0001, 1'b1, 4'h0, 2'd0, 1'b1};

    // Reset state, checked while reset is held across an edge.
    #3;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk_out("rst_early", 1'b0, 4'h0, 2'd0, 1'b0);
    #4;
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_sel", 32'(out_sel), 32'd0);
    chk("rst_out_last", 32'(out_last), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    #5;
    reset = 1'b0;
    tick;

    // Fixed select, round-robin, drain and packet lock.
    for (int i = 0; i < 15; i++) begin
      drive(vecs[i].mode, vecs[i].fsel, vecs[i].valid, vecs[i].last, vecs[i].ordy);
      #1;
      chk($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'(vecs[i].exp_rdy));
      tick;
      chk_out($sformatf("v%0d_out", i), vecs[i].exp_ov, vecs[i].exp_data,
              vecs[i].exp_sel, vecs[i].exp_last);
    end

    // Backpressure: hold 0xA for five stalled cycles, then load in the release cycle.
    in_data[11:8] = 4'hA;
    drive(1'b0, 2'd0, 4'b0100, 4'b0100, 1'b1);
    #1;
    chk("bp_load_ready", 32'(in_ready), 32'b0100);
    tick;
    chk_out("bp_load", 1'b1, 4'hA, 2'd2, 1'b1);
    drive(1'b0, 2'd0, 4'b1000, 4'b1000, 1'b0);
    for (int c = 0; c < 5; c++) begin
      #1;
      chk($sformatf("bp_stall%0d_ready", c), 32'(in_ready), 32'd0);
      tick;
      chk_out($sformatf("bp_stall%0d", c), 1'b1, 4'hA, 2'd2, 1'b1);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", 32'(in_ready), 32'b1000);
    tick;
    chk_out("bp_release", 1'b1, 4'hF, 2'd3, 1'b1);
    drive(1'b0, 2'd0, 4'b0000, 4'b0000, 1'b1);
    tick;
    chk_out("bp_drain", 1'b0, 4'h0, 2'd0, 1'b0);

    // Reset asserted off-edge during beat 2 of a channel-3 packet.
    drive(1'b0, 2'd0, 4'b1000, 4'b0000, 1'b1);
    #1;
    chk("rm_beat1_ready", 32'(in_ready), 32'b1000);
    tick;
    chk_out("rm_beat1", 1'b1, 4'hF, 2'd3, 1'b0);
    #3;
    reset = 1'b1;
    #1;
    chk("rm_in_ready", 32'(in_ready), 32'd0);
    chk("rm_out_valid", 32'(out_valid), 32'd0);
    chk("rm_out_data", 32'(out_data), 32'd0);
    chk("rm_out_sel", 32'(out_sel), 32'd0);
    chk("rm_out_last", 32'(out_last), 32'd0);
    @(posedge clock);
    #2;
    reset = 1'b0;
    drive(1'b0, 2'd0, 4'b0000, 4'b0000, 1'b1);
    tick;
    chk_out("rm_no_beat", 1'b0, 4'h0, 2'd0, 1'b0);
    drive(1'b0, 2'd0, 4'b1001, 4'b1001, 1'b1);
    #1;
    chk("rm_restart_ready", 32'(in_ready), 32'b0001);
    tick;
    chk_out("rm_restart", 1'b1, 4'h0, 2'd0, 1'b1);
    drive(1'b0, 2'd0, 4'b0000, 4'b0000, 1'b1);

    // Three-channel instance: out-of-range fixed select, then mode switch mid-packet.
    for (int c = 0; c < 2; c++) begin
      drive3(1'b1, 2'd3, 3'b111, 3'b111);
      #1;
      chk($sformatf("c3_oor%0d_ready", c), 32'(c3_in_ready), 32'd0);
      tick;
      chk3($sformatf("c3_oor%0d", c), 1'b0, 4'h0, 2'd0, 1'b0);
    end
    drive3(1'b0, 2'd0, 3'b010, 3'b000);
    #1;
    chk("c3_b1_ready", 32'(c3_in_ready), 32'b010);
    tick;
    chk3("c3_b1", 1'b1, 4'h6, 2'd1, 1'b0);
    drive3(1'b1, 2'd0, 3'b011, 3'b000);
    #1;
    chk("c3_b2_ready", 32'(c3_in_ready), 32'b010);
    tick;
    chk3("c3_b2", 1'b1, 4'h6, 2'd1, 1'b0);
    drive3(1'b1, 2'd0, 3'b011, 3'b010);
    #1;
    chk("c3_b3_ready", 32'(c3_in_ready), 32'b010);
    tick;
    chk3("c3_b3", 1'b1, 4'h6, 2'd1, 1'b1);
    drive3(1'b1, 2'd0, 3'b011, 3'b011);
    #1;
    chk("c3_fixed_ready", 32'(c3_in_ready), 32'b001);
    tick;
    chk3("c3_fixed", 1'b1, 4'h3, 2'd0, 1'b1);
    drive3(1'b0, 2'd0, 3'b111, 3'b111);
    #1;
    chk("c3_rr_ready", 32'(c3_in_ready), 32'b100);
    tick;
    chk3("c3_rr", 1'b1, 4'h9, 2'd2, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
